ofm_packer: RTL and testbench

Output-side width converter for the convolution accelerator, and the counterpart of the input-side IFM parser. It accepts narrow result slices (default 80 b) from the PE array and packs 32 of them into a 2560-bit group. It then emits each group as 5 × 512-bit AXI-stream words toward the output DMA. Two group buffers form a ping-pong pair, so one group fills while the other drains.

---
 rtl/ofm_packer.sv | 132 +++++++++++++
 tb/tb_ofm_packer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_packer.sv
// Output-side width converter: packs IN_CNT narrow PE-array slices into a group
// and streams each group out as REG_NUM wide AXI-stream words via a ping-pong pair.
module ofm_packer #(
  parameter int INPUT_WIDTH  = 80,
  parameter int OUTPUT_WIDTH = 512,
  parameter int REG_NUM      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_conv_pulse,
  input  logic [INPUT_WIDTH-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy
);

  // GROUP_BITS must be a whole multiple of INPUT_WIDTH.
  localparam int GROUP_BITS = OUTPUT_WIDTH * REG_NUM;
  localparam int IN_CNT     = GROUP_BITS / INPUT_WIDTH;
  localparam int IN_CW      = (IN_CNT > 1) ? $clog2(IN_CNT) : 1;
  localparam int OUT_CW     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never waits on ready, and out_data/out_last hold while out_valid && !out_ready.

  logic [GROUP_BITS-1:0] grp_q [2];
  logic [1:0]            full_q;
  logic [1:0]            full_d;
  logic                  wr_sel_q;
  logic                  rd_sel_q;
  logic [IN_CW-1:0]      in_cnt_q;
  logic [OUT_CW-1:0]     out_cnt_q;

  logic                  in_fire;
  logic                  in_wrap;
  logic                  out_fire;
  logic                  out_wrap;
  logic                  wr_en;
  logic [GROUP_BITS-1:0] rd_grp;

  assign in_ready  = !full_q[wr_sel_q];
  assign out_valid = full_q[rd_sel_q];
  assign out_last  = out_valid && out_wrap;
  assign busy      = (|full_q) || (in_cnt_q != '0);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign in_wrap  = (in_cnt_q == IN_CW'(IN_CNT - 1));
  assign out_wrap = (out_cnt_q == OUT_CW'(REG_NUM - 1));

  // A conv-start pulse overrides any handshake in the same cycle.
  assign wr_en = in_fire && !start_conv_pulse;

  // Fill-complete and drain-complete can coincide but always hit different buffers.
  always_comb begin
    full_d = full_q;
    if (in_fire && in_wrap) begin
      full_d[wr_sel_q] = 1'b1;
    end
    if (out_fire && out_wrap) begin
      full_d[rd_sel_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else if (start_conv_pulse) begin
      full_q    <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      full_q <= full_d;
      if (in_fire) begin
        if (in_wrap) begin
          in_cnt_q <= '0;
          wr_sel_q <= !wr_sel_q;
        end else begin
          in_cnt_q <= in_cnt_q + IN_CW'(1);
        end
      end
      if (out_fire) begin
        if (out_wrap) begin
          out_cnt_q <= '0;
          rd_sel_q  <= !rd_sel_q;
        end else begin
          out_cnt_q <= out_cnt_q + OUT_CW'(1);
        end
      end
    end
  end

  // Slice s of a group lives at bits [INPUT_WIDTH*s +: INPUT_WIDTH]; slices may
  // straddle output-word boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_q[0] <= '0;
      grp_q[1] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < IN_CNT; s++) begin
          if (wr_sel_q == 1'(b) && in_cnt_q == IN_CW'(s)) begin
            grp_q[b][s*INPUT_WIDTH +: INPUT_WIDTH] <= in_data;
          end
        end
      end
    end
  end

  assign rd_grp = rd_sel_q ? grp_q[1] : grp_q[0];

  // Unregistered word mux; word 0 (lowest group bits) goes out first.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < REG_NUM; k++) begin
      if (out_cnt_q == OUT_CW'(k)) begin
        out_data = rd_grp[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_ofm_packer.sv
// Directed bench for ofm_packer: drivers push expected words into a queue as slices
// are accepted; a negedge monitor pops and compares on each output handshake.
module tb_ofm_packer;
  localparam int IW = 80;
  localparam int OW = 512;
  localparam int RN = 5;
  localparam int GB = OW * RN;
  localparam int IC = GB / IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_conv_pulse;
  logic [IW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;

  ofm_packer #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .REG_NUM(RN)) dut (
    .clk(clk), .rst(rst), .start_conv_pulse(start_conv_pulse),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad = 0;
  int stall_cnt = 0;
  logic [OW-1:0] exp_q[$];
  logic          exp_last_q[$];
  logic [OW-1:0] cap[$];
  logic [GB-1:0] mdl_grp;
  int            mdl_cnt = 0;
  logic [OW-1:0] mon_e;
  logic          mon_l;
  logic [OW-1:0] w;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, OW'(act), OW'(exp));
  endtask

  // scoreboard model: slice i -> group bits [IW*i +: IW], word k -> [OW*k +: OW]
  task automatic model_push(input logic [IW-1:0] d);
    mdl_grp[mdl_cnt*IW +: IW] = d;
    mdl_cnt++;
    if (mdl_cnt == IC) begin
      for (int k = 0; k < RN; k++) begin
        exp_q.push_back(mdl_grp[k*OW +: OW]);
        exp_last_q.push_back(k == RN - 1);
      end
      mdl_cnt = 0;
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %0h want none", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_l = exp_last_q.pop_front();
        chk("word", out_data, mon_e);
        chk1("last", out_last, mon_l);
      end
      cap.push_back(out_data);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // driver: call at posedge+1; returns at posedge+1 after the slice is taken
  task automatic send_slice(input logic [IW-1:0] d);
    int n;
    logic ok;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    if (!in_ready) stall_cnt++;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (ok) model_push(d);
    else begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0 want 1");
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d left want 0", exp_q.size());
    end
    sync();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start_conv_pulse = 1'b0;
    in_valid = 1'b1;
    in_data = 80'hABC;
    out_ready = 1'b0;
    mdl_grp = '0;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk1("post_rst_busy", busy, 1'b0);
    chk1("post_rst_out_valid", out_valid, 1'b0);
    sync();

    // single group, bit mapping
    cap.delete();
    out_ready = 1'b1;
    for (int i = 0; i < IC; i++) send_slice(IW'(i));
    wait_drain();
    chk("single_count", OW'(cap.size()), OW'(5));
    if (cap.size() == 5) begin
      w = cap[0];
      chk("w0_s0", OW'(w[79:0]), OW'(0));
      chk("w0_s1", OW'(w[159:80]), OW'(1));
      chk("w0_s6lo", OW'(w[511:480]), OW'(6));
      w = cap[1];
      chk("w1_s6hi", OW'(w[47:0]), OW'(0));
      chk("w1_s7", OW'(w[127:48]), OW'(7));
      w = cap[4];
      chk("w4_s31", OW'(w[511:432]), OW'(31));
    end
    chk1("single_busy", busy, 1'b0);

    // backpressure
    cap.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 2 * IC; i++) send_slice(IW'(1000 + i));
    @(negedge clk);
    chk1("bp_in_ready_low", in_ready, 1'b0);
    chk1("bp_out_valid", out_valid, 1'b1);
    chk1("bp_busy", busy, 1'b1);
    sync();
    in_data = IW'(5000);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk1("bp_65th_stalls", in_ready, 1'b0);
    sync();
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk1("bp_ready_before_5th", in_ready, 1'b0);
    @(negedge clk);
    chk1("bp_ready_after_5th", in_ready, 1'b1);
    sync();
    in_valid = 1'b0;
    model_push(IW'(5000));
    wait_drain();
    chk("bp_count", OW'(cap.size()), OW'(10));
    if (cap.size() == 10) begin
      w = cap[0];
      chk("bp_g0_first", OW'(w[79:0]), OW'(1000));
      w = cap[5];
      chk("bp_g1_second", OW'(w[79:0]), OW'(1032));
    end
    chk1("bp_partial_busy", busy, 1'b1);
    start_conv_pulse = 1'b1;
    sync();
    start_conv_pulse = 1'b0;
    mdl_cnt = 0;
    @(negedge clk);
    chk1("bp_clear_busy", busy, 1'b0);
    sync();

    // streaming
    cap.delete();
    stall_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4 * IC; i++) send_slice(IW'(2000 + i));
    wait_drain();
    chk("stream_stalls", OW'(stall_cnt), OW'(0));
    chk("stream_count", OW'(cap.size()), OW'(20));

    // conv restart
    cap.delete();
    for (int i = 0; i < 10; i++) send_slice(IW'(3000 + i));
    start_conv_pulse = 1'b1;
    in_valid = 1'b1;
    in_data = IW'(777);
    sync();
    start_conv_pulse = 1'b0;
    in_valid = 1'b0;
    mdl_cnt = 0;
    @(negedge clk);
    chk1("restart_busy_cleared", busy, 1'b0);
    sync();
    for (int i = 0; i < IC; i++) send_slice(IW'(100 + i));
    wait_drain();
    chk("restart_count", OW'(cap.size()), OW'(5));
    if (cap.size() > 0) begin
      w = cap[0];
      chk("restart_first", OW'(w[79:0]), OW'(100));
    end
    chk1("restart_busy_end", busy, 1'b0);

    // async reset mid-drain
    cap.delete();
    for (int i = 0; i < IC; i++) send_slice(IW'(200 + i));
    n = 0;
    while (cap.size() < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("ar_two_words", OW'(cap.size()), OW'(2));
    #1;
    rst = 1'b1;
    #1;
    chk1("ar_out_valid", out_valid, 1'b0);
    chk("ar_out_data", out_data, '0);
    chk1("ar_busy", busy, 1'b0);
    chk1("ar_in_ready", in_ready, 1'b1);
    exp_q.delete();
    exp_last_q.delete();
    mdl_cnt = 0;
    @(posedge clk);
    sync();
    rst = 1'b0;
    cap.delete();
    sync();
    for (int i = 0; i < IC; i++) send_slice(IW'(300 + i));
    wait_drain();
    chk("ar_count", OW'(cap.size()), OW'(5));
    if (cap.size() == 5) begin
      w = cap[0];
      chk("ar_w0", OW'(w[79:0]), OW'(300));
      w = cap[4];
      chk("ar_w4", OW'(w[511:432]), OW'(331));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
